// File: rtl/ysyx_23060203_pkg.sv
// Shared decode definitions: opcodes, immediate types, queue entry layout and
// the immediate extraction helpers used by the queued decode stage.
package ysyx_23060203_pkg;

  localparam int PKG_XLEN = 32;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_Z
  } imm_type_e;

  typedef struct packed {
    logic [PKG_XLEN-1:0] pc;
    logic [31:0]         inst;
    logic                fired;
  } entry_t;

  function automatic imm_type_e imm_type_of(input logic [31:0] inst);
    imm_type_e t;
    case (inst[6:0])
      OP_IMM, OP_LOAD, OP_JALR: t = IMM_I;
      OP_STORE:                 t = IMM_S;
      OP_BRANCH:                t = IMM_B;
      OP_LUI, OP_AUIPC:         t = IMM_U;
      OP_JAL:                   t = IMM_J;
      OP_SYSTEM:                t = inst[14] ? IMM_Z : IMM_I;
      default:                  t = IMM_NONE;
    endcase
    return t;
  endfunction

  function automatic logic [31:0] imm_of(input logic [31:0] inst, input imm_type_e t);
    logic [31:0] imm;
    case (t)
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'd0};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      IMM_Z:   imm = {27'd0, inst[19:15]};
      default: imm = 32'd0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/idu_queued_decode_fwd_mux.sv
// NFWD-way priority operand bypass; channel 0 is the youngest producer and wins.
module idu_fwd_mux #(
  parameter int NFWD = 2,
  parameter int XLEN = 32
) (
  input  logic [4:0]           rs,
  input  logic [XLEN-1:0]      gpr_val,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD-1:0]      fwd_rdy,
  input  logic [NFWD*5-1:0]    fwd_rd,
  input  logic [NFWD*XLEN-1:0] fwd_val,
  output logic [XLEN-1:0]      value,
  output logic                 hazard
);

  // Scan oldest to youngest so the lowest matching index overwrites last.
  always_comb begin
    value  = gpr_val;
    hazard = 1'b0;
    if (rs != 5'd0) begin
      for (int i = NFWD - 1; i >= 0; i--) begin
        if (fwd_valid[i] && (fwd_rd[i*5 +: 5] == rs)) begin
          value  = fwd_val[i*XLEN +: XLEN];
          hazard = !fwd_rdy[i];
        end
      end
    end
  end

endmodule

// File: rtl/ysyx_23060203_BRU.sv
// Branch compare unit: evaluates the RV32 branch condition selected by funct3.
module ysyx_23060203_BRU #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [2:0]      funct3,
  output logic            taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = (src1 == src2);
      3'b001:  taken = (src1 != src2);
      3'b100:  taken = ($signed(src1) <  $signed(src2));
      3'b101:  taken = ($signed(src1) >= $signed(src2));
      3'b110:  taken = (src1 <  src2);
      3'b111:  taken = (src1 >= src2);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/idu_queued_decode.sv
// Decode stage with a DEPTH-entry instruction queue, operand bypass, static
// BTFN branch resolution, wrong-path squash and pending-result stalls.
module idu_queued_decode
  import ysyx_23060203_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int NFWD  = 2,
  parameter int XLEN  = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  output logic [4:0]           rs1,
  output logic [4:0]           rs2,
  input  logic [XLEN-1:0]      src1,
  input  logic [XLEN-1:0]      src2,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD-1:0]      fwd_rdy,
  input  logic [NFWD*5-1:0]    fwd_rd,
  input  logic [NFWD*XLEN-1:0] fwd_val,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [31:0]          in_inst,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc,
  output logic [31:0]          out_inst,
  output logic [XLEN-1:0]      out_src1,
  output logic [XLEN-1:0]      out_src2,
  output logic [XLEN-1:0]      out_imm,
  output logic [4:0]           out_rd,
  output logic                 jump_flush,
  output logic [XLEN-1:0]      jump_dnpc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  entry_t      head;
  logic        head_valid;
  logic [6:0]  opcode;
  imm_type_e   imm_type;
  logic [31:0] imm32;
  logic        hazard1, hazard2, use1, use2, stall;
  logic        is_branch, is_jal, is_jalr, bru_taken, redirect;
  logic        push, pop;
  logic [XLEN-1:0] target;

  assign head       = mem_q[rd_ptr_q];
  assign head_valid = (count_q != '0);
  assign opcode     = head.inst[6:0];
  assign rs1        = head.inst[19:15];
  assign rs2        = head.inst[24:20];
  assign imm_type   = imm_type_of(head.inst);
  assign imm32      = imm_of(head.inst, imm_type);

  idu_fwd_mux #(.NFWD(NFWD), .XLEN(XLEN)) u_fwd1 (
    .rs(rs1), .gpr_val(src1), .fwd_valid(fwd_valid), .fwd_rdy(fwd_rdy),
    .fwd_rd(fwd_rd), .fwd_val(fwd_val), .value(out_src1), .hazard(hazard1)
  );

  idu_fwd_mux #(.NFWD(NFWD), .XLEN(XLEN)) u_fwd2 (
    .rs(rs2), .gpr_val(src2), .fwd_valid(fwd_valid), .fwd_rdy(fwd_rdy),
    .fwd_rd(fwd_rd), .fwd_val(fwd_val), .value(out_src2), .hazard(hazard2)
  );

  ysyx_23060203_BRU #(.XLEN(XLEN)) u_bru (
    .src1(out_src1), .src2(out_src2), .funct3(head.inst[14:12]), .taken(bru_taken)
  );

  // Only sources the opcode actually reads can stall the head.
  always_comb begin
    use1 = 1'b0;
    use2 = 1'b0;
    case (opcode)
      OP_JALR, OP_LOAD, OP_IMM: use1 = 1'b1;
      OP_BRANCH, OP_STORE, OP_OP: begin
        use1 = 1'b1;
        use2 = 1'b1;
      end
      OP_SYSTEM: use1 = !head.inst[14] && (head.inst[13:12] != 2'b00);
      default: ;
    endcase
  end

  assign stall     = (use1 && hazard1) || (use2 && hazard2);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);

  always_comb begin
    target = head.pc + XLEN'(4);
    if (is_jal) begin
      target = head.pc + XLEN'(imm32);
    end else if (is_jalr) begin
      target = out_src1 + XLEN'(imm32);
    end else if (is_branch && bru_taken) begin
      target = head.pc + XLEN'(imm32);
    end
  end

  assign redirect = head_valid && !stall && !head.fired &&
                    (is_jal || is_jalr || (is_branch && (bru_taken ^ head.inst[31])));

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never waits on ready. flush suppresses both out_valid and jump_flush.
  assign in_ready   = (count_q != CNT_FULL);
  assign out_valid  = head_valid && !stall && !flush;
  assign jump_flush = redirect && !flush;
  assign jump_dnpc  = {target[XLEN-1:1], 1'b0};
  assign out_pc     = XLEN'(head.pc);
  assign out_inst   = head.inst;
  assign out_imm    = XLEN'(imm32);
  assign out_rd     = (is_branch || opcode == OP_STORE) ? 5'd0 : head.inst[11:7];

  assign pop  = out_valid && out_ready;
  assign push = in_valid && in_ready && !jump_flush && !flush;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (jump_flush) begin
      // Everything younger than the head is on the wrong path.
      wr_ptr_d = rd_ptr_q + PTR_ONE;
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        count_d  = '0;
      end else begin
        mem_d[rd_ptr_q].fired = 1'b1;
        count_d = CNT_ONE;
      end
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{pc: PKG_XLEN'(in_pc), inst: in_inst, fired: 1'b0};
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_idu_queued_decode.sv
// Directed bench for idu_queued_decode: queue ordering, bypass priority,
// load stalls, branch/jump redirects, squash, flush and reset.
module tb_idu_queued_decode;

  localparam int NFWD = 2;
  localparam int XLEN = 32;

  localparam logic [31:0] I_ADDI1 = 32'h00100093;
  localparam logic [31:0] I_ADDI2 = 32'h00200113;
  localparam logic [31:0] I_ADDI3 = 32'h00300193;
  localparam logic [31:0] I_ADD   = 32'h000280B3;
  localparam logic [31:0] I_BEQ   = 32'h00028863;
  localparam logic [31:0] I_JAL   = 32'h008000EF;
  localparam logic [31:0] I_BNE   = 32'hFE529CE3;
  localparam logic [31:0] I_JALR  = 32'h004280E7;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 flush;
  logic [4:0]           rs1, rs2;
  logic [XLEN-1:0]      src1, src2;
  logic [NFWD-1:0]      fwd_valid, fwd_rdy;
  logic [NFWD*5-1:0]    fwd_rd;
  logic [NFWD*XLEN-1:0] fwd_val;
  logic                 in_valid, in_ready;
  logic [XLEN-1:0]      in_pc;
  logic [31:0]          in_inst;
  logic                 out_valid, out_ready;
  logic [XLEN-1:0]      out_pc;
  logic [31:0]          out_inst;
  logic [XLEN-1:0]      out_src1, out_src2, out_imm;
  logic [4:0]           out_rd;
  logic                 jump_flush;
  logic [XLEN-1:0]      jump_dnpc;

  int checks = 0;
  int failures = 0;

  idu_queued_decode #(.DEPTH(2), .NFWD(NFWD), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .rs1(rs1), .rs2(rs2), .src1(src1), .src2(src2),
    .fwd_valid(fwd_valid), .fwd_rdy(fwd_rdy), .fwd_rd(fwd_rd), .fwd_val(fwd_val),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_src1(out_src1), .out_src2(out_src2), .out_imm(out_imm), .out_rd(out_rd),
    .jump_flush(jump_flush), .jump_dnpc(jump_dnpc)
  );

  // Clock / reset
  always #5 clock = ~clock;

  // Register file model: xN holds 0x1000|N, x0 reads zero.
  always_comb begin
    src1 = (rs1 == 5'd0) ? 32'd0 : (32'h1000 | {27'd0, rs1});
    src2 = (rs2 == 5'd0) ? 32'd0 : (32'h1000 | {27'd0, rs2});
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_fwd(input int ch, input logic v, input logic r,
                         input logic [4:0] rd, input logic [XLEN-1:0] val);
    fwd_valid[ch] = v;
    fwd_rdy[ch] = r;
    fwd_rd[ch*5 +: 5] = rd;
    fwd_val[ch*XLEN +: XLEN] = val;
  endtask

  task automatic drive_in(input logic v, input logic [31:0] pc, input logic [31:0] inst);
    in_valid = v;
    in_pc = pc;
    in_inst = inst;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive_in(1'b0, 32'd0, 32'd0);
    fwd_valid = '0; fwd_rdy = '0; fwd_rd = '0; fwd_val = '0;
    tick(); tick();
    reset = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (jump_flush !== 1'b0) begin failures++; $display("FAIL reset_jump_flush got=%b exp=0", jump_flush); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_fifo_order();
    drive_in(1'b1, 32'h100, I_ADDI1);
    tick();
    drive_in(1'b1, 32'h104, I_ADDI2);
    #2;
    checks++; if (out_pc !== 32'h100 || out_valid !== 1'b1) begin failures++; $display("FAIL fifo_head0 got pc=%h v=%b exp pc=100 v=1", out_pc, out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL fifo_ready1 got=%b exp=1", in_ready); end
    tick();
    drive_in(1'b1, 32'h108, I_ADDI3);
    #2;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fifo_full got=%b exp=0", in_ready); end
    tick();
    #2;
    checks++; if (in_ready !== 1'b0 || out_pc !== 32'h100) begin failures++; $display("FAIL fifo_held got rdy=%b pc=%h exp rdy=0 pc=100", in_ready, out_pc); end
    out_ready = 1'b1;
    #1;
    checks++; if (out_inst !== I_ADDI1) begin failures++; $display("FAIL fifo_inst0 got=%h exp=%h", out_inst, I_ADDI1); end
    tick();
    #2;
    checks++; if (out_pc !== 32'h104 || in_ready !== 1'b1) begin failures++; $display("FAIL fifo_head1 got pc=%h rdy=%b exp pc=104 rdy=1", out_pc, in_ready); end
    tick();
    drive_in(1'b0, 32'd0, 32'd0);
    #2;
    checks++; if (out_pc !== 32'h108 || out_inst !== I_ADDI3) begin failures++; $display("FAIL fifo_head2 got pc=%h inst=%h exp pc=108 inst=%h", out_pc, out_inst, I_ADDI3); end
    tick();
    out_ready = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fifo_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_forward_priority();
    set_fwd(0, 1'b1, 1'b1, 5'd5, 32'hAAAA);
    set_fwd(1, 1'b1, 1'b1, 5'd5, 32'hBBBB);
    drive_in(1'b1, 32'h120, I_ADD);
    tick();
    drive_in(1'b0, 32'd0, 32'd0);
    #2;
    checks++; if (out_src1 !== 32'hAAAA) begin failures++; $display("FAIL fwd_prio got=%h exp=0000aaaa", out_src1); end
    checks++; if (out_src2 !== 32'd0 || out_rd !== 5'd1 || out_valid !== 1'b1) begin failures++; $display("FAIL fwd_misc got src2=%h rd=%0d v=%b exp 0/1/1", out_src2, out_rd, out_valid); end
    set_fwd(0, 1'b1, 1'b1, 5'd6, 32'hAAAA);
    #1;
    checks++; if (out_src1 !== 32'hBBBB) begin failures++; $display("FAIL fwd_ch1 got=%h exp=0000bbbb", out_src1); end
    set_fwd(0, 1'b0, 1'b0, 5'd0, 32'd0);
    set_fwd(1, 1'b0, 1'b0, 5'd0, 32'd0);
    #1;
    checks++; if (out_src1 !== 32'h1005) begin failures++; $display("FAIL fwd_gpr got=%h exp=00001005", out_src1); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_load_stall_branch();
    set_fwd(0, 1'b1, 1'b0, 5'd5, 32'h1234);
    drive_in(1'b1, 32'h200, I_BEQ);
    tick();
    drive_in(1'b1, 32'h204, I_ADDI2);
    for (int c = 0; c < 3; c++) begin
      #2;
      checks++; if (out_valid !== 1'b0 || jump_flush !== 1'b0) begin failures++; $display("FAIL stall_cyc%0d got v=%b jf=%b exp 0/0", c, out_valid, jump_flush); end
      tick();
      drive_in(1'b0, 32'd0, 32'd0);
    end
    set_fwd(0, 1'b1, 1'b1, 5'd5, 32'd0);
    #2;
    checks++; if (jump_flush !== 1'b1 || jump_dnpc !== 32'h210) begin failures++; $display("FAIL beq_redirect got jf=%b dnpc=%h exp 1/00000210", jump_flush, jump_dnpc); end
    checks++; if (out_valid !== 1'b1 || out_rd !== 5'd0 || in_ready !== 1'b0) begin failures++; $display("FAIL beq_head got v=%b rd=%0d rdy=%b exp 1/0/0", out_valid, out_rd, in_ready); end
    tick();
    #2;
    checks++; if (jump_flush !== 1'b0 || in_ready !== 1'b1 || out_pc !== 32'h200) begin failures++; $display("FAIL beq_after got jf=%b rdy=%b pc=%h exp 0/1/200", jump_flush, in_ready, out_pc); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    set_fwd(0, 1'b0, 1'b0, 5'd0, 32'd0);
    #2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL beq_squash got=%b exp=0", out_valid); end
  endtask

  task automatic test_jal_squash();
    drive_in(1'b1, 32'h300, I_JAL);
    tick();
    drive_in(1'b1, 32'h304, I_ADDI1);
    #2;
    checks++; if (jump_flush !== 1'b1 || jump_dnpc !== 32'h308) begin failures++; $display("FAIL jal_redirect got jf=%b dnpc=%h exp 1/00000308", jump_flush, jump_dnpc); end
    checks++; if (out_imm !== 32'd8 || out_rd !== 5'd1) begin failures++; $display("FAIL jal_imm got imm=%h rd=%0d exp 8/1", out_imm, out_rd); end
    tick();
    drive_in(1'b0, 32'd0, 32'd0);
    #2;
    checks++; if (jump_flush !== 1'b0 || in_ready !== 1'b1 || out_pc !== 32'h300) begin failures++; $display("FAIL jal_count1 got jf=%b rdy=%b pc=%h exp 0/1/300", jump_flush, in_ready, out_pc); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL jal_push_drop got=%b exp=0", out_valid); end
  endtask

  task automatic test_backward_and_jalr();
    drive_in(1'b1, 32'h400, I_BNE);
    tick();
    drive_in(1'b0, 32'd0, 32'd0);
    #2;
    checks++; if (jump_flush !== 1'b1 || jump_dnpc !== 32'h404) begin failures++; $display("FAIL bne_redirect got jf=%b dnpc=%h exp 1/00000404", jump_flush, jump_dnpc); end
    for (int c = 0; c < 2; c++) begin
      tick();
      #2;
      checks++; if (jump_flush !== 1'b0 || out_valid !== 1'b1) begin failures++; $display("FAIL bne_refire%0d got jf=%b v=%b exp 0/1", c, jump_flush, out_valid); end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    drive_in(1'b1, 32'h440, I_JALR);
    tick();
    drive_in(1'b0, 32'd0, 32'd0);
    #2;
    checks++; if (jump_flush !== 1'b1 || jump_dnpc !== 32'h1008 || out_imm !== 32'd4) begin failures++; $display("FAIL jalr_redirect got jf=%b dnpc=%h imm=%h exp 1/00001008/4", jump_flush, jump_dnpc, out_imm); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0 || jump_flush !== 1'b0) begin failures++; $display("FAIL jalr_pop got v=%b jf=%b exp 0/0", out_valid, jump_flush); end
  endtask

  task automatic test_flush_and_reset();
    drive_in(1'b1, 32'h500, I_JAL);
    tick();
    drive_in(1'b1, 32'h504, I_ADDI1);
    flush = 1'b1;
    out_ready = 1'b1;
    #2;
    checks++; if (out_valid !== 1'b0 || jump_flush !== 1'b0) begin failures++; $display("FAIL flush_gate got v=%b jf=%b exp 0/0", out_valid, jump_flush); end
    tick();
    flush = 1'b0;
    out_ready = 1'b0;
    drive_in(1'b0, 32'd0, 32'd0);
    #2;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL flush_empty got v=%b rdy=%b exp 0/1", out_valid, in_ready); end
    drive_in(1'b1, 32'h600, I_ADDI1);
    tick();
    drive_in(1'b1, 32'h604, I_ADDI2);
    tick();
    drive_in(1'b0, 32'd0, 32'd0);
    #2;
    checks++; if (in_ready !== 1'b0 || out_pc !== 32'h600) begin failures++; $display("FAIL prereset_full got rdy=%b pc=%h exp 0/600", in_ready, out_pc); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || jump_flush !== 1'b0) begin failures++; $display("FAIL midreset got v=%b rdy=%b jf=%b exp 0/1/0", out_valid, in_ready, jump_flush); end
  endtask

  initial begin
    test_reset();
    test_fifo_order();
    test_forward_priority();
    test_load_stall_branch();
    test_jal_squash();
    test_backward_and_jalr();
    test_flush_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
